// File: rtl/fp_mul_pkg.sv
// Shared types, constants and helper functions for the pipelined FP multiplier.
package fp_mul_pkg;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_t;

  // Bit positions inside the 4-bit flags vector {invalid, overflow, underflow, inexact}
  localparam int FLAG_INV = 3;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set, rest zero
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] q;
    q = ((64'd1 << exp_w) - 64'd1) << man_w;
    q = q | (64'd1 << (man_w - 1));
    return q;
  endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Third pipeline stage of fp_mul_pipe: normalise the raw mantissa product,
// extract guard/sticky, round, range-check the exponent and pack the result.
// Macro FP_MUL_RNE_EN selects round-to-nearest-even; without it the mantissa
// is truncated and guard/sticky only feed the inexact flag.
module fp_mul_round
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W,
  localparam int EW = EXP_W + 2,
  localparam int PW = 2 * MAN_W + 2
) (
  input  logic                 sign,
  input  logic signed [EW-1:0] exp_sum,
  input  logic [PW-1:0]        prod,
  output logic [W-1:0]         result,
  output logic [3:0]           flags
);

  localparam logic signed [EW-1:0] ONE     = 1;
  localparam logic signed [EW-1:0] ZERO_E  = 0;
  localparam logic signed [EW-1:0] EXP_TOP = EW'((1 << EXP_W) - 1);

  logic [MAN_W-1:0]        man_n;
  logic                    g;
  logic                    s;
  logic signed [EW-1:0]    exp_n;
  logic [MAN_W-1:0]        man_f;
  logic signed [EW-1:0]    exp_f;

  // Normalise: a product in [2,4) is shifted right once and the exponent bumped
  always_comb begin
    if (prod[PW-1]) begin
      man_n = prod[2*MAN_W:MAN_W+1];
      g     = prod[MAN_W];
      s     = |prod[MAN_W-1:0];
      exp_n = exp_sum + ONE;
    end else begin
      man_n = prod[2*MAN_W-1:MAN_W];
      g     = prod[MAN_W-1];
      s     = |prod[MAN_W-2:0];
      exp_n = exp_sum;
    end
  end

`ifdef FP_MUL_RNE_EN
  logic rnd_up;
  logic carry;

  // Round to nearest even; a mantissa carry-out leaves man=0 and bumps the exponent
  always_comb begin
    rnd_up         = g & (s | man_n[0]);
    {carry, man_f} = {1'b0, man_n} + {{MAN_W{1'b0}}, rnd_up};
    exp_f          = carry ? (exp_n + ONE) : exp_n;
  end
`else
  // Truncate toward zero
  always_comb begin
    man_f = man_n;
    exp_f = exp_n;
  end
`endif

  // Range check after rounding, then pack
  always_comb begin
    flags = '0;
    if (exp_f >= EXP_TOP) begin
      result          = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags[FLAG_OVF] = 1'b1;
      flags[FLAG_INX] = 1'b1;
    end else if (exp_f <= ZERO_E) begin
      result          = {sign, {(W-1){1'b0}}};
      flags[FLAG_UNF] = 1'b1;
      flags[FLAG_INX] = 1'b1;
    end else begin
      result          = {sign, exp_f[EXP_W-1:0], man_f};
      flags[FLAG_INX] = g | s;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Fully pipelined floating-point multiplier, 3-cycle latency, one op per cycle.
// S1 classifies operands and resolves special values, S2 multiplies the
// mantissas, S3 (fp_mul_round) normalises, rounds and packs.
// Optional macro FP_MUL_RNE_EN (inside fp_mul_round) enables round-to-nearest-even.
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic [W-1:0] dataa,
  input  logic [W-1:0] datab,
  output logic         done,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EW-1:0] BIAS      = EW'(fp_bias(EXP_W));
  localparam logic [63:0]          QNAN_FULL = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN      = QNAN_FULL[W-1:0];

  function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0)
      return FP_ZERO;
    else if (&e)
      return (m == '0) ? FP_INF : FP_NAN;
    else
      return FP_NORM;
  endfunction

  fp_class_t            cls_a;
  fp_class_t            cls_b;
  logic                 sign_in;
  logic signed [EW-1:0] exp_in;
  logic                 spec_in;
  logic [W-1:0]         spec_val_in;
  logic [3:0]           spec_flags_in;

  logic                 s1_valid;
  logic                 s1_sign;
  logic signed [EW-1:0] s1_exp;
  logic [MAN_W:0]       s1_ma;
  logic [MAN_W:0]       s1_mb;
  logic                 s1_spec;
  logic [W-1:0]         s1_spec_val;
  logic [3:0]           s1_spec_flags;

  logic                 s2_valid;
  logic                 s2_sign;
  logic signed [EW-1:0] s2_exp;
  logic [PW-1:0]        s2_prod;
  logic                 s2_spec;
  logic [W-1:0]         s2_spec_val;
  logic [3:0]           s2_spec_flags;

  logic [W-1:0]         rnd_result;
  logic [3:0]           rnd_flags;

  // Stage 1 combinational: classify, sign, biased exponent sum, special results
  always_comb begin
    cls_a         = classify(dataa[W-2:MAN_W], dataa[MAN_W-1:0]);
    cls_b         = classify(datab[W-2:MAN_W], datab[MAN_W-1:0]);
    sign_in       = dataa[W-1] ^ datab[W-1];
    exp_in        = $signed({2'b00, dataa[W-2:MAN_W]}) + $signed({2'b00, datab[W-2:MAN_W]}) - BIAS;
    spec_in       = 1'b0;
    spec_val_in   = '0;
    spec_flags_in = '0;
    if (cls_a == FP_NAN || cls_b == FP_NAN ||
        (cls_a == FP_INF && cls_b == FP_ZERO) || (cls_a == FP_ZERO && cls_b == FP_INF)) begin
      spec_in                 = 1'b1;
      spec_val_in             = QNAN;
      spec_flags_in[FLAG_INV] = 1'b1;
    end else if (cls_a == FP_INF || cls_b == FP_INF) begin
      spec_in     = 1'b1;
      spec_val_in = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cls_a == FP_ZERO || cls_b == FP_ZERO) begin
      spec_in     = 1'b1;
      spec_val_in = {sign_in, {(W-1){1'b0}}};
    end
  end

  // Stage 1 register: valid bit cleared by reset so in-flight ops are dropped
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= enable;
    end
  end

  // Stage 1 datapath register
  always_ff @(posedge clk) begin
    s1_sign       <= sign_in;
    s1_exp        <= exp_in;
    s1_ma         <= {1'b1, dataa[MAN_W-1:0]};
    s1_mb         <= {1'b1, datab[MAN_W-1:0]};
    s1_spec       <= spec_in;
    s1_spec_val   <= spec_val_in;
    s1_spec_flags <= spec_flags_in;
  end

  // Stage 2 valid bit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
    end
  end

  // Stage 2 datapath: full mantissa product, specials carried alongside
  always_ff @(posedge clk) begin
    s2_sign       <= s1_sign;
    s2_exp        <= s1_exp;
    s2_prod       <= PW'(s1_ma) * PW'(s1_mb);
    s2_spec       <= s1_spec;
    s2_spec_val   <= s1_spec_val;
    s2_spec_flags <= s1_spec_flags;
  end

  fp_mul_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .sign    (s2_sign),
    .exp_sum (s2_exp),
    .prod    (s2_prod),
    .result  (rnd_result),
    .flags   (rnd_flags)
  );

  // Stage 3 output register: result/flags only update on a valid op, otherwise hold
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      done   <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else begin
      done <= s2_valid;
      if (s2_valid) begin
        result <= s2_spec ? s2_spec_val : rnd_result;
        flags  <= s2_spec ? s2_spec_flags : rnd_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (EXP_W=8, MAN_W=23): directed cases plus
// random operands scored against an integer-arithmetic reference model.
module tb_fp_mul_pipe;

  typedef struct {
    logic        v;
    logic [31:0] r;
    logic [3:0]  f;
  } exp_entry_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        done;
  logic [31:0] result;
  logic [3:0]  flags;

  int          checks = 0;
  int          failures = 0;
  exp_entry_t  exp_q[$];
  logic [31:0] last_res;
  logic        chk_rst_flags;

  fp_mul_pipe dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .dataa   (dataa),
    .datab   (datab),
    .done    (done),
    .result  (result),
    .flags   (flags)
  );

  always #5 clk = ~clk;

  // Reference: decode, multiply with plain integers, round by comparing the remainder to half an ulp
  function automatic exp_entry_t model(input logic [31:0] a, input logic [31:0] b);
    exp_entry_t       e;
    int               ea, eb, ex, drop;
    longint unsigned  ma, mb, p, kept, rem, half;
    logic             sgn, inexact;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    e.v = 1'b1;
    e.f = 4'b0000;
    sgn = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      e.r = 32'h7FC00000;
      e.f = 4'b1000;
    end else if (a_inf || b_inf) begin
      e.r = {sgn, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      e.r = {sgn, 31'h0};
    end else begin
      ma = 64'h800000 + longint'(a[22:0]);
      mb = 64'h800000 + longint'(b[22:0]);
      p  = ma * mb;
      ex = ea + eb - 127;
      drop = 23;
      if (p >= (64'd1 << 47)) begin
        drop = 24;
        ex = ex + 1;
      end
      kept = p >> drop;
      rem  = p & ((64'd1 << drop) - 64'd1);
      half = 64'd1 << (drop - 1);
      inexact = (rem != 0);
`ifdef FP_MUL_RNE_EN
      if (rem > half || (rem == half && kept[0])) kept = kept + 1;
      if (kept == (64'd1 << 24)) begin
        kept = 64'd1 << 23;
        ex = ex + 1;
      end
`endif
      if (ex >= 255) begin
        e.r = {sgn, 8'hFF, 23'h0};
        e.f = 4'b0101;
      end else if (ex <= 0) begin
        e.r = {sgn, 31'h0};
        e.f = 4'b0011;
      end else begin
        e.r = {sgn, ex[7:0], kept[22:0]};
        e.f = {3'b000, inexact};
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] randOp();
    logic [31:0] x;
    int          k;
    x = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0: x[30:0] = 31'h0;
      1: x[30:0] = {8'hFF, 23'h0};
      2: begin x[30:23] = 8'hFF; x[0] = 1'b1; end
      3: x[30:23] = 8'h00;
      4: x[22:0] = 23'h7FFFFF;
      5, 6: x[30:23] = 8'($urandom_range(1, 254));
      default: x[30:23] = 8'($urandom_range(100, 154));
    endcase
    return x;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  // One cycle: check what the DUT shows now, then drive the next inputs and predict them
  task automatic applyStimulus(input logic en, input logic rst_n_v, input logic [31:0] a, input logic [31:0] b);
    exp_entry_t e;
    exp_entry_t idle;
    idle.v = 1'b0;
    idle.r = 32'h0;
    idle.f = 4'h0;
    @(negedge clk);
    e = exp_q.pop_front();
    checkOutput("done", {31'h0, done}, {31'h0, e.v});
    if (e.v) last_res = e.r;
    checkOutput("result", result, last_res);
    if (e.v) checkOutput("flags", {28'h0, flags}, {28'h0, e.f});
    if (chk_rst_flags) checkOutput("rst_flags", {28'h0, flags}, 32'h0);
    chk_rst_flags = 1'b0;
    enable  = en;
    reset_n = rst_n_v;
    dataa   = a;
    datab   = b;
    if (!rst_n_v) begin
      exp_q.delete();
      exp_q.push_back(idle);
      exp_q.push_back(idle);
      exp_q.push_back(idle);
      last_res = 32'h0;
      chk_rst_flags = 1'b1;
    end else begin
      exp_q.push_back(en ? model(a, b) : idle);
    end
  endtask

  initial begin
    exp_entry_t idle;
    idle.v = 1'b0;
    idle.r = 32'h0;
    idle.f = 4'h0;
    reset_n = 1'b0;
    enable  = 1'b0;
    dataa   = 32'h0;
    datab   = 32'h0;
    last_res = 32'h0;
    chk_rst_flags = 1'b1;
    repeat (3) exp_q.push_back(idle);

    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);

    // 3.0 x 2.5
    applyStimulus(1'b1, 1'b1, 32'h40400000, 32'h40200000);
    repeat (4) applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);

    // Back-to-back issue, bubble, two more
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, randOp(), randOp());
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h3F800000, 32'hC0000000);
    applyStimulus(1'b1, 1'b1, 32'h3FA00000, 32'h3FA00000);

    // Specials, range limits, rounding
    applyStimulus(1'b1, 1'b1, 32'h7F800000, 32'h00000000);
    applyStimulus(1'b1, 1'b1, 32'hFF800000, 32'h40000000);
    applyStimulus(1'b1, 1'b1, 32'h7FC00001, 32'h3F800000);
    applyStimulus(1'b1, 1'b1, 32'h7F7FFFFF, 32'h40000000);
    applyStimulus(1'b1, 1'b1, 32'h80800000, 32'h3F000000);
    applyStimulus(1'b1, 1'b1, 32'h3FC00001, 32'h3FC00001);
    applyStimulus(1'b1, 1'b1, 32'h00400000, 32'hC0000000);
    applyStimulus(1'b1, 1'b1, 32'h3FFFFFFF, 32'h3FFFFFFF);
    repeat (4) applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);

    // Reset with ops in flight
    applyStimulus(1'b1, 1'b1, 32'h40400000, 32'h40400000);
    applyStimulus(1'b1, 1'b1, 32'h40800000, 32'h40800000);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h40400000, 32'h40200000);
    repeat (4) applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);

    // Random traffic with random bubbles
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 1'b1, randOp(), randOp());
    end
    repeat (4) applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
